mmio_bus_decoder: RTL and testbench

//  Parametrised memory-mapped I/O decoder between the drisc core bus and its peripherals (RAM, user input, video, ...).

---
 rtl/mmio_pkg.sv | 22 ++
 rtl/mmio_region_match.sv | 31 +++
 rtl/mmio_bus_decoder.sv | 157 +++++++++++++++
 tb/tb_mmio_bus_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and default memory map for the drisc MMIO bus decoder.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  // Default drisc map: RAM low, a 4-byte user-input window, video from 16 MiB up.
  localparam logic [31:0] RAM_BASE          = 32'h00000000;
  localparam logic [31:0] RAM_LIMIT         = 32'h00fffffb;
  localparam logic [31:0] USER_INPUT_BASE   = 32'h00fffffc;
  localparam logic [31:0] USER_INPUT_LIMIT  = 32'h00ffffff;
  localparam logic [31:0] VIDEO_BASE        = 32'h01000000;
  localparam logic [31:0] VIDEO_LIMIT       = 32'hffffffff;

  function automatic int region_index_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/mmio_region_match.sv
// Combinational window compare: finds the lowest-index region whose
// inclusive [base, limit] window contains the address.
module mmio_region_match
  import mmio_pkg::*;
#(
  parameter int                       REGION_COUNT = 4,
  parameter logic [REGION_COUNT*32-1:0] REGION_BASE  = '0,
  parameter logic [REGION_COUNT*32-1:0] REGION_LIMIT = '0,
  localparam int                      IDX_W        = region_index_width(REGION_COUNT)
) (
  input  logic [31:0]      address,
  output logic             hit,
  output logic [IDX_W-1:0] index,
  output logic [31:0]      base
);

  // Scan from the top down so the lowest matching index is written last and wins.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    base  = '0;
    for (int i = REGION_COUNT - 1; i >= 0; i--) begin
      if ((address >= REGION_BASE[i*32 +: 32]) && (address <= REGION_LIMIT[i*32 +: 32])) begin
        hit   = 1'b1;
        index = IDX_W'(i);
        base  = REGION_BASE[i*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/mmio_bus_decoder.sv
// MMIO decoder for the drisc core bus: latch, window match, wait states, one-cycle strobes.
// Optional fault logging is enabled with `define MMIO_DECODER_FAULT_LOG_EN.
module mmio_bus_decoder
  import mmio_pkg::*;
#(
  parameter int                              REGION_COUNT     = 4,
  parameter int                              LOCAL_ADDR_WIDTH = 12,
  parameter int                              WAIT_WIDTH       = 4,
  parameter logic [REGION_COUNT*32-1:0]      REGION_BASE      = {VIDEO_BASE, USER_INPUT_BASE, RAM_BASE, 32'h0},
  parameter logic [REGION_COUNT*32-1:0]      REGION_LIMIT     = {VIDEO_LIMIT, USER_INPUT_LIMIT, RAM_LIMIT, 32'h0},
  parameter logic [REGION_COUNT*WAIT_WIDTH-1:0] REGION_WAIT   = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [31:0]                 address_bus,
  input  logic                        write_address,
  input  logic                        write,
  input  logic                        read,
  output logic [31:0]                 latched_address,
  output logic [LOCAL_ADDR_WIDTH-1:0] local_address,
  output logic [REGION_COUNT-1:0]     region_write,
  output logic [REGION_COUNT-1:0]     region_read,
  output logic                        ready,
  output logic                        busy,
  output logic                        bus_fault,
  output logic [31:0]                 fault_address,
  output logic [7:0]                  fault_count
);

  localparam int IDX_W = region_index_width(REGION_COUNT);

  state_t                      state, state_next;
  logic [31:0]                 latched_q;
  logic [WAIT_WIDTH-1:0]       wait_count, wait_next, sel_wait;
  logic [IDX_W-1:0]            access_index;
  logic                        access_write, access_fault;
  logic [LOCAL_ADDR_WIDTH-1:0] local_q;
  logic                        match_hit;
  logic [IDX_W-1:0]            match_index;
  logic [31:0]                 match_base, offset;
  logic                        request, req_fault, capture, issuing;
  logic                        unused_offset_bits;

  mmio_region_match #(
    .REGION_COUNT (REGION_COUNT),
    .REGION_BASE  (REGION_BASE),
    .REGION_LIMIT (REGION_LIMIT)
  ) u_match (
    .address (latched_q),
    .hit     (match_hit),
    .index   (match_index),
    .base    (match_base)
  );

  assign request            = read ^ write;
  assign req_fault          = (read & write) | ~match_hit;
  assign offset             = latched_q - match_base;
  assign unused_offset_bits = ^offset[31:LOCAL_ADDR_WIDTH];

  always_comb begin
    sel_wait = '0;
    for (int i = 0; i < REGION_COUNT; i++) begin
      if (match_index == IDX_W'(i)) sel_wait = REGION_WAIT[i*WAIT_WIDTH +: WAIT_WIDTH];
    end
  end

  // A read&write conflict is captured too, so it can be reported as a fault.
  always_comb begin
    state_next = state;
    wait_next  = wait_count;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (request || (read && write)) begin
          capture = 1'b1;
          if (req_fault || (sel_wait == '0)) begin
            state_next = ISSUE;
          end else begin
            state_next = WAIT;
            wait_next  = sel_wait;
          end
        end
      end
      WAIT: begin
        wait_next = wait_count - 1'b1;
        if (wait_count <= WAIT_WIDTH'(1)) state_next = ISSUE;
      end
      ISSUE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      latched_q    <= '0;
      wait_count   <= '0;
      access_index <= '0;
      access_write <= 1'b0;
      access_fault <= 1'b0;
      local_q      <= '0;
    end else begin
      state      <= state_next;
      wait_count <= wait_next;
      if (write_address) latched_q <= address_bus;
      if (capture) begin
        access_index <= match_index;
        access_write <= write;
        access_fault <= req_fault;
        local_q      <= offset[LOCAL_ADDR_WIDTH-1:0];
      end
    end
  end

  assign issuing = (state == ISSUE);

  always_comb begin
    region_write = '0;
    region_read  = '0;
    for (int i = 0; i < REGION_COUNT; i++) begin
      region_write[i] = issuing & ~access_fault &  access_write & (access_index == IDX_W'(i));
      region_read[i]  = issuing & ~access_fault & ~access_write & (access_index == IDX_W'(i));
    end
  end

  assign ready           = issuing;
  assign busy            = (state != IDLE);
  assign bus_fault       = issuing & access_fault;
  assign latched_address = latched_q;
  assign local_address   = local_q;

`ifdef MMIO_DECODER_FAULT_LOG_EN
  logic [31:0] access_address, fault_address_q;
  logic [7:0]  fault_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      access_address  <= '0;
      fault_address_q <= '0;
      fault_count_q   <= '0;
    end else begin
      if (capture) access_address <= latched_q;
      if (bus_fault) begin
        fault_address_q <= access_address;
        if (fault_count_q != 8'hff) fault_count_q <= fault_count_q + 8'd1;
      end
    end
  end

  assign fault_address = fault_address_q;
  assign fault_count   = fault_count_q;
`else
  assign fault_address = '0;
  assign fault_count   = '0;
`endif

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Directed bench for mmio_bus_decoder: default map instance plus a wait-state map instance.
module tb_mmio_bus_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_bus = '0;
  logic        write_address = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;

  logic [31:0] d_latched, w_latched, d_fault_address, w_fault_address;
  logic [11:0] d_local, w_local;
  logic [3:0]  d_rw, d_rr, w_rw, w_rr;
  logic        d_ready, d_busy, d_fault, w_ready, w_busy, w_fault;
  logic [7:0]  d_fault_count, w_fault_count;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clock = ~clock;

  mmio_bus_decoder dut (
    .clock(clock), .reset(reset), .address_bus(address_bus), .write_address(write_address),
    .write(write), .read(read), .latched_address(d_latched), .local_address(d_local),
    .region_write(d_rw), .region_read(d_rr), .ready(d_ready), .busy(d_busy), .bus_fault(d_fault),
    .fault_address(d_fault_address), .fault_count(d_fault_count)
  );

  // Region waits 0..3 = 0,1,2,0.
  mmio_bus_decoder #(.REGION_WAIT({4'd0, 4'd2, 4'd1, 4'd0})) dut_w (
    .clock(clock), .reset(reset), .address_bus(address_bus), .write_address(write_address),
    .write(write), .read(read), .latched_address(w_latched), .local_address(w_local),
    .region_write(w_rw), .region_read(w_rr), .ready(w_ready), .busy(w_busy), .bus_fault(w_fault),
    .fault_address(w_fault_address), .fault_count(w_fault_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic latch(input logic [31:0] a);
    address_bus   = a;
    write_address = 1'b1;
    step();
    write_address = 1'b0;
  endtask

  task automatic request(input logic rd, input logic wr);
    read  = rd;
    write = wr;
    step();
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_compared++; if (d_latched !== 32'h0) begin n_mismatched++; $display("FAIL reset_latched: got %h want %h", d_latched, 32'h0); end
    n_compared++; if (d_local !== 12'h0) begin n_mismatched++; $display("FAIL reset_local: got %h want %h", d_local, 12'h0); end
    n_compared++; if ({d_rw, d_rr} !== 8'h00) begin n_mismatched++; $display("FAIL reset_strobes: got %b want %b", {d_rw, d_rr}, 8'h00); end
    n_compared++; if ({d_ready, d_busy, d_fault} !== 3'b000) begin n_mismatched++; $display("FAIL reset_status: got %b want %b", {d_ready, d_busy, d_fault}, 3'b000); end
    n_compared++; if ({d_fault_address, d_fault_count} !== 40'h0) begin n_mismatched++; $display("FAIL reset_log: got %h want %h", {d_fault_address, d_fault_count}, 40'h0); end
  endtask

  task automatic test_basic_read();
    latch(32'h00000010);
    request(1'b1, 1'b0);
    n_compared++; if (d_rr !== 4'b0010) begin n_mismatched++; $display("FAIL read_strobe: got %b want %b", d_rr, 4'b0010); end
    n_compared++; if (d_rw !== 4'b0000) begin n_mismatched++; $display("FAIL read_no_write: got %b want %b", d_rw, 4'b0000); end
    n_compared++; if ({d_ready, d_busy, d_fault} !== 3'b110) begin n_mismatched++; $display("FAIL read_status: got %b want %b", {d_ready, d_busy, d_fault}, 3'b110); end
    n_compared++; if (d_local !== 12'h010) begin n_mismatched++; $display("FAIL read_local: got %h want %h", d_local, 12'h010); end
    step();
    n_compared++; if ({d_rr, d_ready, d_busy} !== 6'b0) begin n_mismatched++; $display("FAIL read_done: got %b want %b", {d_rr, d_ready, d_busy}, 6'b0); end
    n_compared++; if (d_local !== 12'h010) begin n_mismatched++; $display("FAIL read_local_hold: got %h want %h", d_local, 12'h010); end
  endtask

  task automatic test_write();
    latch(32'h01000020);
    request(1'b0, 1'b1);
    n_compared++; if (d_rw !== 4'b1000) begin n_mismatched++; $display("FAIL write_strobe: got %b want %b", d_rw, 4'b1000); end
    n_compared++; if (d_rr !== 4'b0000) begin n_mismatched++; $display("FAIL write_no_read: got %b want %b", d_rr, 4'b0000); end
    n_compared++; if (d_local !== 12'h020) begin n_mismatched++; $display("FAIL write_local: got %h want %h", d_local, 12'h020); end
    n_compared++; if (d_ready !== 1'b1) begin n_mismatched++; $display("FAIL write_ready: got %b want %b", d_ready, 1'b1); end
    step();
  endtask

  task automatic test_boundaries();
    latch(32'h00000000);
    request(1'b1, 1'b0);
    n_compared++; if ({d_rr, d_local} !== {4'b0001, 12'h000}) begin n_mismatched++; $display("FAIL prio_addr0: got %b/%h want %b/%h", d_rr, d_local, 4'b0001, 12'h000); end
    step();
    latch(32'h00fffffb);
    request(1'b1, 1'b0);
    n_compared++; if ({d_rr, d_local} !== {4'b0010, 12'hffb}) begin n_mismatched++; $display("FAIL ram_limit: got %b/%h want %b/%h", d_rr, d_local, 4'b0010, 12'hffb); end
    step();
    latch(32'h00ffffff);
    request(1'b0, 1'b1);
    n_compared++; if ({d_rw, d_local} !== {4'b0100, 12'h003}) begin n_mismatched++; $display("FAIL user_limit: got %b/%h want %b/%h", d_rw, d_local, 4'b0100, 12'h003); end
    step();
    latch(32'hffffffff);
    request(1'b1, 1'b0);
    n_compared++; if ({d_rr, d_local} !== {4'b1000, 12'hfff}) begin n_mismatched++; $display("FAIL video_top: got %b/%h want %b/%h", d_rr, d_local, 4'b1000, 12'hfff); end
    step();
  endtask

  task automatic test_same_edge();
    latch(32'h00000004);
    address_bus   = 32'h01000000;
    write_address = 1'b1;
    request(1'b1, 1'b0);
    write_address = 1'b0;
    n_compared++; if (d_rr !== 4'b0010) begin n_mismatched++; $display("FAIL same_edge_strobe: got %b want %b", d_rr, 4'b0010); end
    n_compared++; if (d_local !== 12'h004) begin n_mismatched++; $display("FAIL same_edge_local: got %h want %h", d_local, 12'h004); end
    n_compared++; if (d_latched !== 32'h01000000) begin n_mismatched++; $display("FAIL same_edge_latch: got %h want %h", d_latched, 32'h01000000); end
    step();
    step();
    step();
  endtask

  task automatic test_wait_states();
    latch(32'h00fffffc);
    request(1'b1, 1'b0);
    n_compared++; if ({w_busy, w_ready, w_rr} !== 6'b100000) begin n_mismatched++; $display("FAIL wait_c1: got %b want %b", {w_busy, w_ready, w_rr}, 6'b100000); end
    request(1'b1, 1'b0);
    n_compared++; if ({w_busy, w_ready, w_rr} !== 6'b100000) begin n_mismatched++; $display("FAIL wait_c2: got %b want %b", {w_busy, w_ready, w_rr}, 6'b100000); end
    step();
    n_compared++; if ({w_busy, w_ready, w_rr} !== 6'b110100) begin n_mismatched++; $display("FAIL wait_c3_strobe: got %b want %b", {w_busy, w_ready, w_rr}, 6'b110100); end
    n_compared++; if (w_local !== 12'h000) begin n_mismatched++; $display("FAIL wait_local: got %h want %h", w_local, 12'h000); end
    step();
    n_compared++; if ({w_busy, w_ready} !== 2'b00) begin n_mismatched++; $display("FAIL wait_idle: got %b want %b", {w_busy, w_ready}, 2'b00); end
    step();
    n_compared++; if ({w_busy, w_ready, w_rr} !== 6'b0) begin n_mismatched++; $display("FAIL wait_no_queue: got %b want %b", {w_busy, w_ready, w_rr}, 6'b0); end
  endtask

  task automatic test_reset_mid_access();
    latch(32'h00fffffc);
    request(1'b1, 1'b0);
    n_compared++; if (w_busy !== 1'b1) begin n_mismatched++; $display("FAIL abort_in_wait: got %b want %b", w_busy, 1'b1); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_compared++; if ({w_busy, w_ready, w_fault, w_rr, w_rw} !== 11'b0) begin n_mismatched++; $display("FAIL abort_status: got %b want %b", {w_busy, w_ready, w_fault, w_rr, w_rw}, 11'b0); end
    n_compared++; if ({w_latched, w_local} !== 44'h0) begin n_mismatched++; $display("FAIL abort_regs: got %h want %h", {w_latched, w_local}, 44'h0); end
    step();
    step();
    n_compared++; if ({w_ready, w_rr} !== 5'b0) begin n_mismatched++; $display("FAIL abort_no_strobe: got %b want %b", {w_ready, w_rr}, 5'b0); end
  endtask

  task automatic test_fault();
    latch(32'h00000000);
    request(1'b1, 1'b1);
    n_compared++; if ({d_fault, d_ready, d_busy} !== 3'b111) begin n_mismatched++; $display("FAIL fault_status: got %b want %b", {d_fault, d_ready, d_busy}, 3'b111); end
    n_compared++; if ({d_rr, d_rw} !== 8'h00) begin n_mismatched++; $display("FAIL fault_no_strobe: got %b want %b", {d_rr, d_rw}, 8'h00); end
    step();
    n_compared++; if ({d_fault, d_ready} !== 2'b00) begin n_mismatched++; $display("FAIL fault_pulse_end: got %b want %b", {d_fault, d_ready}, 2'b00); end
`ifdef MMIO_DECODER_FAULT_LOG_EN
    n_compared++; if (d_fault_count !== 8'd1) begin n_mismatched++; $display("FAIL fault_count1: got %h want %h", d_fault_count, 8'd1); end
    n_compared++; if (d_fault_address !== 32'h0) begin n_mismatched++; $display("FAIL fault_addr: got %h want %h", d_fault_address, 32'h0); end
`else
    n_compared++; if ({d_fault_address, d_fault_count} !== 40'h0) begin n_mismatched++; $display("FAIL fault_log_off: got %h want %h", {d_fault_address, d_fault_count}, 40'h0); end
`endif
  endtask

  task automatic test_fault_saturation();
    for (int i = 0; i < 300; i++) begin
      request(1'b1, 1'b1);
      step();
    end
`ifdef MMIO_DECODER_FAULT_LOG_EN
    n_compared++; if (d_fault_count !== 8'hff) begin n_mismatched++; $display("FAIL fault_saturate: got %h want %h", d_fault_count, 8'hff); end
`else
    n_compared++; if (d_fault_count !== 8'h00) begin n_mismatched++; $display("FAIL fault_count_off: got %h want %h", d_fault_count, 8'h00); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write();
    test_boundaries();
    test_same_edge();
    test_wait_states();
    test_reset_mid_access();
    test_fault();
    test_fault_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
